// File: rtl/dsp_file_arbiter.sv
// Round-robin arbiter giving NUM_REQ equation engines turns on the single DSP file-access port.
// Optional build macro DSP_FILE_ARB_TIMEOUT_EN adds a GRANT-state watchdog that abandons a transfer never acknowledged by file_active.
module dsp_file_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [8*NUM_REQ-1:0]   req_file_num,
    input  logic [NUM_REQ-1:0]     req_file_read,
    input  logic [NUM_REQ-1:0]     req_file_write,
    input  logic [32*NUM_REQ-1:0]  req_file_write_data,
    output logic [NUM_REQ-1:0]     req_file_active,
    output logic [31:0]            req_file_read_data,
    output logic [7:0]             file_num,
    output logic                   file_read,
    output logic                   file_write,
    output logic [31:0]            file_write_data,
    input  logic [31:0]            file_read_data,
    input  logic                   file_active,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   arb_error
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("dsp_file_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..65535");
    end

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [IDX_W-1:0]     gidx_reg, gidx_next;
    logic [7:0]           file_num_reg, file_num_next;
    logic                 file_read_reg, file_read_next;
    logic                 file_write_reg, file_write_next;
    logic [31:0]          file_write_data_reg, file_write_data_next;
    logic                 arb_error_reg, arb_error_next;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
    logic [15:0]          timeout_cnt_reg, timeout_cnt_next;
`endif

    logic [NUM_REQ-1:0]   req_vec;
    logic [7:0]           num_arr  [NUM_REQ];
    logic [31:0]          data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_vec[gi]         = req_file_read[gi] | req_file_write[gi];
            assign num_arr[gi]         = req_file_num[8*gi +: 8];
            assign data_arr[gi]        = req_file_write_data[32*gi +: 32];
            assign req_file_active[gi] = file_active & grant_reg[gi];
        end
    endgenerate

    // Rotating priority: the search starts just after the last winner so nobody waits more than NUM_REQ grants.
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_REQ-1:0]   sel_onehot;
    int                   cand;

    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_reg) + k) % NUM_REQ;
            if (!sel_found && req_vec[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        sel_onehot[sel_idx] = 1'b1;
    end

    logic g_rd, g_wr;
    assign g_rd = req_file_read[gidx_reg];
    assign g_wr = req_file_write[gidx_reg];

    always_comb begin
        state_next           = state_reg;
        grant_next           = grant_reg;
        last_grant_next      = last_grant_reg;
        gidx_next            = gidx_reg;
        file_num_next        = file_num_reg;
        file_read_next       = 1'b0;
        file_write_next      = 1'b0;
        file_write_data_next = file_write_data_reg;
        arb_error_next       = arb_error_reg;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
        timeout_cnt_next     = timeout_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (sel_found) begin
                    state_next      = ST_GRANT;
                    grant_next      = sel_onehot;
                    last_grant_next = sel_idx;
                    gidx_next       = sel_idx;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
                    timeout_cnt_next = 16'd0;
`endif
                end
            end
            ST_GRANT: begin
                file_num_next        = num_arr[gidx_reg];
                file_write_data_next = data_arr[gidx_reg];
                if (file_active) begin
                    state_next = ST_BUSY;
                end
`ifdef DSP_FILE_ARB_TIMEOUT_EN
                else if (timeout_cnt_reg == 16'(TIMEOUT)) begin
                    arb_error_next = 1'b1;
                    grant_next     = '0;
                    state_next     = ST_IDLE;
                end
`endif
                else if (!(g_rd || g_wr)) begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    // Read+write together is a requester bug; the write wins so data is never silently dropped.
                    file_read_next  = g_rd & ~g_wr;
                    file_write_next = g_wr;
                    if (g_rd && g_wr) begin
                        arb_error_next = 1'b1;
                    end
`ifdef DSP_FILE_ARB_TIMEOUT_EN
                    timeout_cnt_next = timeout_cnt_reg + 16'd1;
`endif
                end
            end
            ST_BUSY: begin
                if (!file_active) begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_reg           <= ST_IDLE;
            grant_reg           <= '0;
            last_grant_reg      <= IDX_W'(NUM_REQ - 1);
            gidx_reg            <= '0;
            file_num_reg        <= '0;
            file_read_reg       <= 1'b0;
            file_write_reg      <= 1'b0;
            file_write_data_reg <= '0;
            arb_error_reg       <= 1'b0;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
            timeout_cnt_reg     <= 16'd0;
`endif
        end else begin
            state_reg           <= state_next;
            grant_reg           <= grant_next;
            last_grant_reg      <= last_grant_next;
            gidx_reg            <= gidx_next;
            file_num_reg        <= file_num_next;
            file_read_reg       <= file_read_next;
            file_write_reg      <= file_write_next;
            file_write_data_reg <= file_write_data_next;
            arb_error_reg       <= arb_error_next;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
            timeout_cnt_reg     <= timeout_cnt_next;
`endif
        end
    end

    assign grant              = grant_reg;
    assign busy               = (state_reg != ST_IDLE);
    assign arb_error          = arb_error_reg;
    assign file_num           = file_num_reg;
    assign file_read          = file_read_reg;
    assign file_write         = file_write_reg;
    assign file_write_data    = file_write_data_reg;
    assign req_file_read_data = file_read_data;

endmodule

// File: doc/dsp_file_arbiter.md
Name: dsp_file_arbiter

Overview:
- Round-robin arbiter sharing the single DSP file-access port among NUM_REQ equation engines (multiply, add, filter, ...).
- Each engine drives its own file_num/file_read/file_write/file_write_data. The arbiter grants one engine at a time and holds the grant for one complete transfer, until file_active rises and then falls.
- Sits between the equation engines and the DSP file block, inside the DSP slave.

Parameters:
- NUM_REQ, 4, number of requesting equation engines (2..8)
- TIMEOUT, 1024, cycles allowed between downstream strobe and file_active assertion (used only with the optional feature)

Ports:
- wb_clk  input  1  system clock
- wb_rst  input  1  asynchronous active-high reset
- req_file_num  input  8*NUM_REQ  file number per requester; requester i at [8i+7:8i]
- req_file_read  input  NUM_REQ  read strobe per requester
- req_file_write  input  NUM_REQ  write strobe per requester
- req_file_write_data  input  32*NUM_REQ  write data per requester
- req_file_active  output  NUM_REQ  file_active routed to the granted requester only
- req_file_read_data  output  32  file_read_data broadcast to all requesters
- file_num  output  8  to file block
- file_read  output  1  to file block
- file_write  output  1  to file block
- file_write_data  output  32  to file block
- file_read_data  input  32  from file block
- file_active  input  1  from file block
- grant  output  NUM_REQ  one-hot grant, all-zero when idle
- busy  output  1  high in GRANT or BUSY
- arb_error  output  1  sticky error flag

Behaviour:
- Reset: state=IDLE, grant=0, busy=0, file_num=0, file_read=0, file_write=0, file_write_data=0, arb_error=0, last_grant=NUM_REQ-1 so requester 0 wins the first arbitration.
- Request condition: req_i = req_file_read[i] | req_file_write[i].
- State IDLE:
  - If any req_i, grant the first requesting index searching from last_grant+1 with wrap-around.
  - Register grant, last_grant and granted index; go to GRANT.
  - Downstream strobes stay 0.
- State GRANT:
  - Every cycle, register the granted requester's file_num, file_read, file_write and file_write_data onto the downstream outputs. The strobe appears one cycle after entry.
  - file_active high -> go to BUSY; file_read=0 and file_write=0 from the next cycle.
  - Granted requester drops both strobes before file_active is seen (abort) -> drop downstream strobes, go to IDLE, keep last_grant updated.
- State BUSY:
  - Strobes held 0; file_num and file_write_data held.
  - file_active low -> grant=0, go to IDLE.
  - The next arbitration happens in that IDLE cycle, so back-to-back transfers are separated by at least 2 cycles.
- Routing:
  - req_file_active[i] = file_active & grant[i], combinational; ungranted requesters always see 0.
  - req_file_read_data = file_read_data, combinational passthrough.
- Protocol error: granted requester asserts read and write together in GRANT -> forward as write only (file_read=0) and set arb_error.
- arb_error clears only on reset.
- Non-granted requests are ignored and held pending; no request is lost, and each requester is served within NUM_REQ grants.
- file_active asserting in IDLE (stray) is ignored; no requester sees it.
- Reset mid-transfer: immediate return to the reset values above, regardless of file_active.

Optional Feature:
- Macro DSP_FILE_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to GRANT and increments each GRANT cycle while file_active is low.
  - At count == TIMEOUT: drop strobes, set arb_error, grant=0, go to IDLE.
  - The counter resets to 0 on wb_rst.
- Undefined: no counter; GRANT waits indefinitely for file_active.

Test Plan:
- Single read: requester 1 raises req_file_read with file_num=8'h03; file block raises file_active 3 cycles later for 4 cycles, read data 32'hDEADBEEF -> grant=4'b0010, file_read=1 with file_num=3, req_file_active[1] mirrors file_active, req_file_read_data=32'hDEADBEEF, grant returns to 0 after file_active falls.
- Round-robin: requesters 0, 2 and 3 request simultaneously after reset and keep re-requesting -> grant order 0, 2, 3, 0, 2; no requester is granted twice in a row while others wait.
- Write path: requester 3 writes 32'h12345678 to file 8'h07 while requester 0 reads file 8'h01 -> downstream shows exactly one transfer at a time; file_write_data=32'h12345678 only while grant=4'b1000.
- Abort and protocol error:
  - Requester 2 drops its strobe before file_active -> IDLE with no downstream strobe afterward.
  - Requester 1 asserts read and write together -> file_write=1, file_read=0, arb_error=1.
- Reset mid-transfer: assert wb_rst asynchronously in BUSY with file_active=1 -> all outputs 0 immediately; after release, requester 0 wins a tie with requester 1.
- Timeout (macro defined, TIMEOUT=16): grant requester 0 and never assert file_active -> strobe drops and arb_error=1 at GRANT entry + 16 cycles, then requester 1 is granted.
